// File: rtl/pipeline_stall_ctrl.sv
// Purpose : ID-stage hazard consumer; drives PC / IF/ID / ID/EX enables and flushes,
//           runs the debug halt/step FSM and keeps saturating performance counters.
// Latency : outputs are combinational from registered state and current inputs (0 cycles).
// Backpressure: stall_req freezes PC and IF/ID and bubbles ID/EX; DRAIN/HALTED freeze the front end.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   stall_req           load-use stall from the hazard unit
//   flush_req           ID/EX bubble request (branch operand hazard)
//   branch_taken        branch/jump resolved in ID; kills IF/ID unless stalled
//   halt_req            debug halt, level or pulse
//   step_req/resume_req debug single-step / resume pulses
//   clear_counters      zero all performance counters
//   pc_write            PC register enable
//   if_id_write         IF/ID register enable
//   if_id_flush         IF/ID loads NOP
//   id_ex_flush         ID/EX loads bubble
//   halted              high only while halted
//   cycle_count         active (RUN/STEP) cycles
//   stall_count         active cycles with stall_req
//   flush_count         active cycles with flush_req or an honoured branch
module pipeline_stall_ctrl #(
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_req,
    input  logic             flush_req,
    input  logic             branch_taken,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic             resume_req,
    input  logic             clear_counters,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    // Drain counter holds DRAIN_CYCLES-1 down to 0; keep at least one bit.
    localparam int            DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;
    localparam logic [1:0] S_STEP   = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [DW-1:0]    r_drain_cnt;
    logic [DW-1:0]    w_drain_cnt_nxt;
    logic             w_active;
    logic             w_branch_ok;
    logic             w_stall_evt;
    logic             w_flush_evt;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign w_active    = (r_state == S_RUN) || (r_state == S_STEP);
    // A stall wins over a branch: the branch re-resolves once the stall clears.
    assign w_branch_ok = branch_taken & ~stall_req;
    assign w_stall_evt = w_active & stall_req;
    assign w_flush_evt = w_active & (flush_req | w_branch_ok);

    // Pipeline control outputs.
    always_comb begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        halted      = 1'b0;
        if (!reset) begin
            if (w_active) begin
                pc_write    = ~stall_req;
                if_id_write = ~stall_req;
                if_id_flush = w_branch_ok;
                id_ex_flush = stall_req | flush_req;
            end else begin
                // Front end frozen, back end fed bubbles until empty.
                if_id_flush = 1'b0;
                id_ex_flush = 1'b1;
                halted      = (r_state == S_HALTED);
            end
        end
    end

    // Halt / step FSM next state.
    always_comb begin
        w_state_nxt     = r_state;
        w_drain_cnt_nxt = r_drain_cnt;
        case (r_state)
            S_RUN: begin
                if (halt_req) begin
                    w_state_nxt     = S_DRAIN;
                    w_drain_cnt_nxt = DRAIN_LOAD;
                end
            end
            S_DRAIN: begin
                // Debug requests are deliberately ignored while draining.
                if (r_drain_cnt == '0) begin
                    w_state_nxt = S_HALTED;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt - DW'(1);
                end
            end
            S_HALTED: begin
                if (resume_req) begin
                    w_state_nxt = S_RUN;
                end else if (step_req) begin
                    w_state_nxt = S_STEP;
                end
            end
            default: begin
                // STEP: one instruction issued, then drain it back to HALTED.
                w_state_nxt     = S_DRAIN;
                w_drain_cnt_nxt = DRAIN_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_RUN;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
        end
    end

    // Performance counters; clear beats increment and leaves the FSM alone.
    always_ff @(posedge clk) begin
        if (reset || clear_counters) begin
            r_cycle_cnt <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_active) begin
                r_cycle_cnt <= sat_inc(r_cycle_cnt);
            end
            if (w_stall_evt) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
            if (w_flush_evt) begin
                r_flush_cnt <= sat_inc(r_flush_cnt);
            end
        end
    end

    assign cycle_count = r_cycle_cnt;
    assign stall_count = r_stall_cnt;
    assign flush_count = r_flush_cnt;

endmodule
